// File: rtl/hamming_dec_engine.sv
// hamming_dec_engine: memory-to-memory Hamming(15,11) single-error-correcting
// decoder. Reads NWORDS encoded 16-bit words (two bytes each) from SRC_BASE,
// corrects/extracts the 11 data bits and writes them back as two bytes at
// DST_BASE, then pulses ack for one cycle.
// Optional feature: define HAMMING_ERR_CNT_EN to enable the saturating
// corrected-word counter on err_cnt (otherwise err_cnt is tied to 0).
module hamming_dec_engine #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int SRC_BASE = 64,
    parameter int DST_BASE = 94,
    parameter int NWORDS   = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    output logic          ack,
    output logic [AW-1:0] mem_addr,
    input  logic [DW-1:0] mem_rdata,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    output logic [3:0]    err_cnt
);

    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_LO,
        RD_HI,
        WR_LO,
        WR_HI,
        DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [IW-1:0]  idx;
    logic [7:0]     lo_q;
    logic [10:0]    data_q;

    logic [15:1]    w_raw;
    logic [15:1]    w_fix;
    logic [3:0]     syn;
    logic [10:0]    d_ext;
    logic [AW-1:0]  word_off;
    logic           unused_parity;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state sequencing through the read/write phases of each word
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req) state_nxt = RD_LO;
            RD_LO:   state_nxt = RD_HI;
            RD_HI:   state_nxt = WR_LO;
            WR_LO:   state_nxt = WR_HI;
            WR_HI:   state_nxt = (idx == LAST_IDX) ? DONE : RD_LO;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Syndrome, single-bit correction and data-bit extraction for the word
    // formed from the latched low byte and the high byte being read now
    always_comb begin
        w_raw = {mem_rdata[6:0], lo_q};
        syn   = '0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (w_raw[k]) syn = syn ^ 4'(k);
        end
        w_fix = w_raw;
        if (syn != '0) w_fix[syn] = ~w_fix[syn];
        d_ext = {w_fix[15:9], w_fix[7:5], w_fix[3]};
        // parity positions only feed the syndrome, never the output data
        unused_parity = ^{w_fix[8], w_fix[4], w_fix[2], w_fix[1]};
    end

    // Word index, low-byte latch and decoded-data register
    always_ff @(posedge clk) begin
        if (reset) begin
            idx    <= '0;
            lo_q   <= '0;
            data_q <= '0;
        end else begin
            case (state)
                IDLE:  idx    <= '0;
                RD_LO: lo_q   <= mem_rdata[7:0];
                RD_HI: data_q <= d_ext;
                WR_HI: if (idx != LAST_IDX) idx <= idx + 1'b1;
                default: ;
            endcase
        end
    end

    // Memory interface and ack decoded from the current state
    always_comb begin
        ack       = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        word_off  = AW'({idx, 1'b0});
        case (state)
            RD_LO: mem_addr = AW'(SRC_BASE) + word_off;
            RD_HI: mem_addr = AW'(SRC_BASE) + word_off + AW'(1);
            WR_LO: begin
                mem_we    = 1'b1;
                mem_addr  = AW'(DST_BASE) + word_off;
                mem_wdata = DW'(data_q[7:0]);
            end
            WR_HI: begin
                mem_we    = 1'b1;
                mem_addr  = AW'(DST_BASE) + word_off + AW'(1);
                mem_wdata = DW'({5'b0, data_q[10:8]});
            end
            DONE:  ack = 1'b1;
            default: ;
        endcase
    end

`ifdef HAMMING_ERR_CNT_EN
    logic [3:0] err_q;

    // Count words needing correction; cleared on job start, saturates at 15
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= '0;
        end else if (state == IDLE && req) begin
            err_q <= '0;
        end else if (state == RD_HI && syn != '0 && err_q != 4'd15) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign err_cnt = err_q;
`else
    assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_hamming_dec_engine.sv
// tb_hamming_dec_engine: randomized self-checking bench for hamming_dec_engine
// with a behavioural Hamming(15,11) reference model and a memory model.
module tb_hamming_dec_engine;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int SRC = 64;
    localparam int DST = 94;
    localparam int NW  = 15;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req = 1'b0;
    logic          ack;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [3:0]    err_cnt;

    int checks = 0;
    int failures = 0;

    logic [7:0] src_img [0:2*NW-1];
    logic [7:0] exp_b   [0:2*NW-1];
    int         exp_err;

    int         cyc = 0;
    int         ack_cnt = 0;
    int         ack_edge = 0;
    int         wr_cnt = 0;
    logic [7:0] wr_addr [0:4095];
    logic [7:0] wr_data [0:4095];

    hamming_dec_engine #(
        .AW(AW), .DW(DW), .SRC_BASE(SRC), .DST_BASE(DST), .NWORDS(NW)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .ack(ack),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Asynchronous-read memory: source image inside the source window
    always_comb begin
        if (int'(mem_addr) >= SRC && int'(mem_addr) < SRC + 2*NW)
            mem_rdata = src_img[int'(mem_addr) - SRC];
        else
            mem_rdata = 8'hA5;
    end

    // Monitor: values present just before each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (ack) begin
            ack_cnt  = ack_cnt + 1;
            ack_edge = cyc;
        end
        if (mem_we) begin
            if (wr_cnt < 4096) begin
                wr_addr[wr_cnt] = mem_addr;
                wr_data[wr_cnt] = mem_wdata;
            end
            wr_cnt = wr_cnt + 1;
        end
    end

    function automatic bit is_pow2(input int k);
        return (k & (k - 1)) == 0;
    endfunction

    function automatic logic [15:0] encode(input logic [10:0] d);
        logic [15:0] w;
        int j;
        bit par;
        w = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if (!is_pow2(k)) begin
                w[k] = d[j];
                j++;
            end
        end
        for (int b = 0; b < 4; b++) begin
            par = 1'b0;
            for (int k = 1; k < 16; k++)
                if (((k >> b) & 1) == 1 && k != (1 << b)) par = par ^ w[k];
            w[1 << b] = par;
        end
        return w;
    endfunction

    task automatic ref_decode(input logic [7:0] hi, input logic [7:0] lo,
                              output logic [10:0] d, output bit err);
        logic [15:0] w;
        int s;
        int j;
        w = {hi[6:0], lo, 1'b0};
        s = 0;
        for (int k = 1; k < 16; k++) if (w[k]) s = s ^ k;
        if (s != 0) w[s] = ~w[s];
        err = (s != 0);
        d = '0;
        j = 0;
        for (int k = 1; k < 16; k++) begin
            if (!is_pow2(k)) begin
                d[j] = w[k];
                j++;
            end
        end
    endtask

    task automatic compute_expect();
        logic [10:0] d;
        bit e;
        exp_err = 0;
        for (int w = 0; w < NW; w++) begin
            ref_decode(src_img[2*w+1], src_img[2*w], d, e);
            exp_b[2*w]   = d[7:0];
            exp_b[2*w+1] = {5'b0, d[10:8]};
            if (e && exp_err < 15) exp_err++;
        end
`ifndef HAMMING_ERR_CNT_EN
        exp_err = 0;
`endif
    endtask

    // Random job: clean codewords, single-bit errors and arbitrary words
    task automatic build_job();
        logic [10:0] d;
        logic [15:0] cw;
        int mode;
        for (int w = 0; w < NW; w++) begin
            d  = 11'($urandom);
            cw = encode(d);
            mode = $urandom_range(0, 2);
            if (mode == 1) cw[$urandom_range(1, 15)] ^= 1'b1;
            if (mode == 2) cw = 16'($urandom);
            src_img[2*w]   = cw[8:1];
            src_img[2*w+1] = {1'($urandom), cw[15:9]};
        end
        compute_expect();
    endtask

    // Pulse req for one cycle and wait for ack; lat = cycles from sample to ack
    task automatic run_job(output int lat, output int start);
        int a0;
        a0 = ack_cnt;
        lat = -1;
        req = 1'b1;
        start = cyc;
        @(negedge clk);
        req = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (ack_cnt > a0) break;
            @(negedge clk);
        end
        if (ack_cnt > a0) lat = ack_edge - start - 1;
    endtask

    task automatic check_writes(input int w0, input int nbytes, input string name);
        for (int j = 0; j < nbytes; j++) begin
            checks++;
            if (int'(wr_addr[w0+j]) !== DST + j) begin
                failures++;
                $display("FAIL %s addr[%0d]: got %0d expected %0d", name, j, wr_addr[w0+j], DST + j);
            end
            checks++;
            if (wr_data[w0+j] !== exp_b[j]) begin
                failures++;
                $display("FAIL %s data[%0d]: got %02h expected %02h", name, j, wr_data[w0+j], exp_b[j]);
            end
        end
    endtask

    task automatic check_lat(input int lat, input string name);
        checks++;
        if (lat !== 4*NW + 1) begin
            failures++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, 4*NW + 1);
        end
    endtask

    task automatic check_err(input string name);
        checks++;
        if (int'(err_cnt) !== exp_err) begin
            failures++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, exp_err);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({ack, mem_we, mem_addr, mem_wdata, err_cnt} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got ack=%b we=%b addr=%0d wdata=%0d err=%0d expected all 0",
                     ack, mem_we, mem_addr, mem_wdata, err_cnt);
        end
        req = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || ack !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got we=%b ack=%b expected 0 0", mem_we, ack);
        end
    endtask

    task automatic test_vectors();
        logic [7:0] v_hi [0:2];
        logic [7:0] v_lo [0:2];
        logic [7:0] e_hi [0:2];
        logic [7:0] e_lo [0:2];
        int lat, start, w0;
        v_hi = '{8'h7F, 8'h3F, 8'h00};
        v_lo = '{8'hFF, 8'hFF, 8'h10};
        e_hi = '{8'h07, 8'h07, 8'h00};
        e_lo = '{8'hFF, 8'hFF, 8'h00};
        for (int v = 0; v < 3; v++) begin
            build_job();
            src_img[0] = v_lo[v];
            src_img[1] = v_hi[v];
            compute_expect();
            w0 = wr_cnt;
            run_job(lat, start);
            check_lat(lat, "vector");
            checks++;
            if (wr_data[w0] !== e_lo[v] || wr_data[w0+1] !== e_hi[v]) begin
                failures++;
                $display("FAIL vector%0d word0: got hi=%02h lo=%02h expected hi=%02h lo=%02h",
                         v, wr_data[w0+1], wr_data[w0], e_hi[v], e_lo[v]);
            end
            check_writes(w0, 2*NW, "vector_job");
            check_err("vector");
        end
    endtask

    task automatic test_full_job();
        int lat, start, w0, a0;
        for (int r = 0; r < 4; r++) begin
            build_job();
            w0 = wr_cnt;
            a0 = ack_cnt;
            run_job(lat, start);
            check_lat(lat, "full_job");
            repeat (5) @(negedge clk);
            checks++;
            if (ack_cnt - a0 !== 1) begin
                failures++;
                $display("FAIL full_job ack_count: got %0d expected 1", ack_cnt - a0);
            end
            checks++;
            if (wr_cnt - w0 !== 2*NW) begin
                failures++;
                $display("FAIL full_job write_count: got %0d expected %0d", wr_cnt - w0, 2*NW);
            end
            check_writes(w0, 2*NW, "full_job");
            check_err("full_job_hold");
        end
    endtask

    task automatic test_req_ignored();
        int a0, w0, start, lat;
        build_job();
        a0 = ack_cnt;
        w0 = wr_cnt;
        lat = -1;
        req = 1'b1;
        start = cyc;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            req = (cyc - start == 20);
            if (ack_cnt > a0 && lat < 0) lat = ack_edge - start - 1;
        end
        req = 1'b0;
        check_lat(lat, "req_ignored");
        checks++;
        if (ack_cnt - a0 !== 1) begin
            failures++;
            $display("FAIL req_ignored ack_count: got %0d expected 1", ack_cnt - a0);
        end
        checks++;
        if (wr_cnt - w0 !== 2*NW) begin
            failures++;
            $display("FAIL req_ignored write_count: got %0d expected %0d", wr_cnt - w0, 2*NW);
        end
        check_writes(w0, 2*NW, "req_ignored");
    endtask

    task automatic test_reset_mid_job();
        int a0, w0, start, lat;
        build_job();
        a0 = ack_cnt;
        w0 = wr_cnt;
        req = 1'b1;
        start = cyc;
        for (int t = 0; t < 100 && (cyc - start) < 30; t++) begin
            @(negedge clk);
            req = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b0 || ack !== 1'b0 || err_cnt !== 4'd0) begin
            failures++;
            $display("FAIL mid_reset outputs: got we=%b ack=%b err=%0d expected 0 0 0", mem_we, ack, err_cnt);
        end
        reset = 1'b0;
        repeat (80) @(negedge clk);
        checks++;
        if (ack_cnt !== a0) begin
            failures++;
            $display("FAIL mid_reset ack_count: got %0d expected 0", ack_cnt - a0);
        end
        checks++;
        if (wr_cnt - w0 !== 14) begin
            failures++;
            $display("FAIL mid_reset write_count: got %0d expected 14", wr_cnt - w0);
        end
        check_writes(w0, 14, "mid_reset_partial");
        build_job();
        w0 = wr_cnt;
        run_job(lat, start);
        check_lat(lat, "after_reset");
        check_writes(w0, 2*NW, "after_reset");
        check_err("after_reset");
    endtask

    task automatic test_back_to_back();
        int a0, w0, start, e1;
        build_job();
        a0 = ack_cnt;
        w0 = wr_cnt;
        e1 = -1;
        req = 1'b1;
        start = cyc;
        for (int t = 0; t < 300 && ack_cnt < a0 + 2; t++) begin
            @(negedge clk);
            if (ack_cnt == a0 + 1 && e1 < 0) e1 = ack_edge;
            if (e1 >= 0 && cyc >= e1 + 1) req = 1'b0;
        end
        req = 1'b0;
        repeat (80) @(negedge clk);
        check_lat(e1 - start - 1, "back_to_back_first");
        checks++;
        if (ack_cnt - a0 !== 2 || ack_edge - e1 !== 4*NW + 2) begin
            failures++;
            $display("FAIL back_to_back second_ack: got acks=%0d gap=%0d expected acks=2 gap=%0d",
                     ack_cnt - a0, ack_edge - e1, 4*NW + 2);
        end
        checks++;
        if (wr_cnt - w0 !== 4*NW) begin
            failures++;
            $display("FAIL back_to_back write_count: got %0d expected %0d", wr_cnt - w0, 4*NW);
        end
        check_writes(w0 + 2*NW, 2*NW, "back_to_back_second");
        check_err("back_to_back");
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_full_job();
        test_req_ignored();
        test_reset_mid_job();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
